// File: rtl/imm_encode_pkg.sv
// imm_encode_pkg: shared immediate-source codes, FSM states and direct-mode encoder
package imm_encode_pkg;
  typedef enum logic [1:0] {IMM8 = 2'b00, IMM12 = 2'b01, BRANCH = 2'b10, ROT8 = 2'b11} imm_src_t;
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;
  localparam logic [3:0] ROT_MAX = 4'd15;
  typedef struct packed {
    logic        ok;
    logic [23:0] field;
  } enc_t;
  // Single-cycle encodings; the rotated mode is handled by the search FSM.
  function automatic enc_t encode_direct(input logic [31:0] v, input imm_src_t s);
    enc_t e;
    e.ok = s == IMM8   ? v[31:8] == 24'd0 :
           s == IMM12  ? v[31:12] == 20'd0 :
           s == BRANCH ? v[1:0] == 2'b00 && v[31:25] == {7{v[25]}} : 1'b0;
    e.field = !e.ok       ? 24'd0 :
              s == IMM8   ? {16'd0, v[7:0]} :
              s == IMM12  ? {12'd0, v[11:0]} : v[25:2];
    return e;
  endfunction
endpackage

// File: rtl/imm_encode_rot_check.sv
// imm_rot_check: tests whether ROL(value, 2*rot) fits in eight bits
module imm_rot_check (
  input  logic [31:0] value,
  input  logic [3:0]  rot,
  output logic        hit,
  output logic [7:0]  imm8
);
  logic [4:0]  sh;
  logic [31:0] t;
  always_comb begin
    sh = {rot, 1'b0};
    for (int i = 0; i < 32; i++) t[i] = value[5'(i) - sh];
    hit = t[31:8] == 24'd0;
    imm8 = t[7:0];
  end
endmodule

// File: rtl/imm_encode.sv
// imm_encode: inverse of the immediate extender with a multi-cycle rotated-immediate search
module imm_encode
  import imm_encode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  input  logic [1:0]  req_src,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_field,
  output logic        rsp_ok
);
  state_t      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [31:0] val_q, val_d;
  logic [23:0] field_q, field_d;
  logic        ok_q, ok_d;
  logic        hit;
  logic [7:0]  imm8;
  enc_t        direct;

  imm_rot_check u_rot (.value(val_q), .rot(rot_q), .hit(hit), .imm8(imm8));

  assign direct    = encode_direct(req_value, imm_src_t'(req_src));
  assign req_ready = state_q == IDLE && !reset;
  assign rsp_valid = state_q == RESP;
  assign rsp_field = field_q;
  assign rsp_ok    = ok_q;

  always_comb begin
    state_d = state_q;
    rot_d = rot_q;
    val_d = val_q;
    field_d = field_q;
    ok_d = ok_q;
    case (state_q)
      IDLE: if (req_valid) begin
        val_d = req_value;
        rot_d = '0;
        state_d = req_src == ROT8 ? SEARCH : RESP;
        field_d = req_src == ROT8 ? field_q : direct.field;
        ok_d = req_src == ROT8 ? ok_q : direct.ok;
      end
      // Rotations are tried in increasing order so the smallest match wins.
      SEARCH: if (hit) begin
        field_d = {12'd0, rot_q, imm8};
        ok_d = 1'b1;
        state_d = RESP;
      end else if (rot_q == ROT_MAX) begin
        field_d = '0;
        ok_d = 1'b0;
        state_d = RESP;
      end else begin
        rot_d = rot_q + 4'd1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rot_q <= '0;
      val_q <= '0;
      field_q <= '0;
      ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rot_q <= rot_d;
      val_q <= val_d;
      field_q <= field_d;
      ok_q <= ok_d;
    end
endmodule
